// File: rtl/mac_fwd_lookup_pkg.sv
// Shared constants for the MAC forwarding lookup stage:
// header field offsets, port count and FSM encoding.
package mac_fwd_lookup_pkg;

    localparam int MAC_W    = 48;
    localparam int PORT_NUM = 4;

    localparam int DST_MSB    = 127;
    localparam int DST_LSB    = 80;
    localparam int SRC_MSB    = 79;
    localparam int SRC_LSB    = 32;
    localparam int TYPE_MSB   = 31;
    localparam int TYPE_LSB   = 16;
    localparam int ING_MSB    = 3;
    localparam int ING_LSB    = 0;
    localparam int DST_IG_BIT = 120;
    localparam int SRC_IG_BIT = 72;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_CAPTURE,
        ST_SEARCH,
        ST_LEARN,
        ST_OUT
    } state_e;

endpackage

// File: rtl/mac_fwd_table.sv
// Aging MAC table: valid/MAC/port/age arrays, age prescaler,
// one write port (flush wins) and one indexed read port.
module mac_fwd_table
    import mac_fwd_lookup_pkg::*;
#(
    parameter int ADDR_LEN    = 3,
    parameter int TICK_CYCLES = 100000000,
    parameter int AGE_LIMIT   = 15
) (
    input  logic                clk,
    input  logic                arst_n,
    input  logic                flush_i,
    input  logic                wr_en_i,
    input  logic [ADDR_LEN-1:0] wr_idx_i,
    input  logic [MAC_W-1:0]    wr_mac_i,
    input  logic [PORT_NUM-1:0] wr_port_i,
    input  logic [ADDR_LEN-1:0] rd_idx_i,
    output logic                rd_valid_o,
    output logic [MAC_W-1:0]    rd_mac_o,
    output logic [PORT_NUM-1:0] rd_port_o
);

    localparam int E  = 2 ** ADDR_LEN;
    localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);
    localparam logic [3:0]    AGE_MAX    = 4'(AGE_LIMIT);

    logic [PW-1:0]       presc_q;
    logic [E-1:0]        valid_q;
    logic [MAC_W-1:0]    mac_q  [E];
    logic [PORT_NUM-1:0] port_q [E];
    logic [3:0]          age_q  [E];
    logic [3:0]          age_d  [E];
    logic                tick;

    assign tick = (presc_q == PRESC_LAST);

    always_comb begin
        for (int i = 0; i < E; i++) begin
            age_d[i] = (age_q[i] == 4'hF) ? age_q[i] : age_q[i] + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            presc_q <= '0;
            valid_q <= '0;
            for (int i = 0; i < E; i++) begin
                mac_q[i]  <= '0;
                port_q[i] <= '0;
                age_q[i]  <= '0;
            end
        end else begin
            presc_q <= tick ? '0 : presc_q + 1'b1;
            for (int i = 0; i < E; i++) begin
                if (flush_i) begin
                    valid_q[i] <= 1'b0;
                end else if (wr_en_i && wr_idx_i == ADDR_LEN'(i)) begin
                    valid_q[i] <= 1'b1;
                    mac_q[i]   <= wr_mac_i;
                    port_q[i]  <= wr_port_i;
                    age_q[i]   <= 4'd0;
                end else if (tick && valid_q[i]) begin
                    // an entry that ages to the limit dies in this same update
                    age_q[i] <= age_d[i];
                    if (age_d[i] == AGE_MAX) valid_q[i] <= 1'b0;
                end
            end
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_mac_o   = mac_q[rd_idx_i];
    assign rd_port_o  = port_q[rd_idx_i];

endmodule

// File: rtl/mac_fwd_lookup.sv
// Forwarding decision: pop header, scan table, learn source,
// present header plus egress mask over valid/ready.
module mac_fwd_lookup
    import mac_fwd_lookup_pkg::*;
#(
    parameter int HEADER_DWIDTH   = 128,
    parameter int TABLE_ADDR_LEN  = 3,
    parameter int AGE_TICK_CYCLES = 100000000,
    parameter int AGE_LIMIT       = 15
) (
    input  logic                     clk,
    input  logic                     arst_n,
    input  logic [HEADER_DWIDTH-1:0] h_fifo_dout,
    input  logic                     h_fifo_empty,
    output logic                     h_fifo_rden,
    input  logic [PORT_NUM-1:0]      mask_port,
    input  logic                     flush,
    output logic                     fwd_valid,
    input  logic                     fwd_ready,
    output logic [HEADER_DWIDTH-1:0] fwd_header,
    output logic [PORT_NUM-1:0]      fwd_port_mask,
    output logic                     fwd_hit
);

    localparam int AW = TABLE_ADDR_LEN;
    localparam logic [AW-1:0] LAST = AW'(2 ** AW - 1);

    state_e                   state_q;
    logic [HEADER_DWIDTH-1:0] hdr_q;
    logic [AW-1:0]            idx_q;
    logic [AW-1:0]            src_idx_q;
    logic [AW-1:0]            free_idx_q;
    logic [AW-1:0]            repl_q;
    logic [PORT_NUM-1:0]      dst_port_q;
    logic [PORT_NUM-1:0]      mask_q;
    logic                     dst_hit_q;
    logic                     src_hit_q;
    logic                     free_found_q;
    logic                     force_miss_q;
    logic                     rden_q;
    logic                     valid_q;
    logic                     hit_q;

    logic [MAC_W-1:0]    dst_mac;
    logic [MAC_W-1:0]    src_mac;
    logic [PORT_NUM-1:0] ing;
    logic                ing_ok;
    logic                src_mcast;
    logic                dst_mcast;
    logic [PORT_NUM-1:0] flood;

    logic                rd_valid;
    logic [MAC_W-1:0]    rd_mac;
    logic [PORT_NUM-1:0] rd_port;
    logic                dst_match;
    logic                src_match;

    logic                wr_en;
    logic [AW-1:0]       wr_idx;
    logic                repl_adv;
    logic [PORT_NUM-1:0] mask_d;
    logic                hit_d;

    assign dst_mac   = hdr_q[DST_MSB:DST_LSB];
    assign src_mac   = hdr_q[SRC_MSB:SRC_LSB];
    assign ing       = hdr_q[ING_MSB:ING_LSB];
    assign dst_mcast = hdr_q[DST_IG_BIT];
    assign src_mcast = hdr_q[SRC_IG_BIT];
    assign ing_ok    = (ing != '0) && ((ing & (ing - 1'b1)) == '0);
    assign flood     = ~ing & ~mask_port;

    assign dst_match = rd_valid && (rd_mac == dst_mac);
    assign src_match = rd_valid && (rd_mac == src_mac);

    assign wr_en    = (state_q == ST_LEARN) && ing_ok && !src_mcast
                      && !force_miss_q && !flush;
    assign wr_idx   = src_hit_q    ? src_idx_q  :
                      free_found_q ? free_idx_q : repl_q;
    assign repl_adv = wr_en && !src_hit_q && !free_found_q;

    always_comb begin
        mask_d = '0;
        hit_d  = 1'b0;
        if (!ing_ok) begin
            mask_d = '0;
        end else if (dst_mcast) begin
            mask_d = flood;
        end else if (force_miss_q || flush || !dst_hit_q) begin
            mask_d = flood;
        end else if (dst_port_q == ing) begin
            hit_d = 1'b1;
        end else begin
            mask_d = dst_port_q & ~mask_port;
            hit_d  = 1'b1;
        end
    end

    mac_fwd_table #(
        .ADDR_LEN    (AW),
        .TICK_CYCLES (AGE_TICK_CYCLES),
        .AGE_LIMIT   (AGE_LIMIT)
    ) u_table (
        .clk        (clk),
        .arst_n     (arst_n),
        .flush_i    (flush),
        .wr_en_i    (wr_en),
        .wr_idx_i   (wr_idx),
        .wr_mac_i   (src_mac),
        .wr_port_i  (ing),
        .rd_idx_i   (idx_q),
        .rd_valid_o (rd_valid),
        .rd_mac_o   (rd_mac),
        .rd_port_o  (rd_port)
    );

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q      <= ST_IDLE;
            hdr_q        <= '0;
            idx_q        <= '0;
            src_idx_q    <= '0;
            free_idx_q   <= '0;
            repl_q       <= '0;
            dst_port_q   <= '0;
            mask_q       <= '0;
            dst_hit_q    <= 1'b0;
            src_hit_q    <= 1'b0;
            free_found_q <= 1'b0;
            force_miss_q <= 1'b0;
            rden_q       <= 1'b0;
            valid_q      <= 1'b0;
            hit_q        <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!h_fifo_empty) begin
                        state_q <= ST_READ;
                        rden_q  <= 1'b1;
                    end
                end
                ST_READ: begin
                    rden_q       <= 1'b0;
                    force_miss_q <= 1'b0;
                    state_q      <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    hdr_q        <= h_fifo_dout;
                    idx_q        <= '0;
                    dst_hit_q    <= 1'b0;
                    src_hit_q    <= 1'b0;
                    free_found_q <= 1'b0;
                    if (flush) force_miss_q <= 1'b1;
                    state_q      <= ST_SEARCH;
                end
                ST_SEARCH: begin
                    if (flush) force_miss_q <= 1'b1;
                    if (dst_match && !dst_hit_q) begin
                        dst_hit_q  <= 1'b1;
                        dst_port_q <= rd_port;
                    end
                    if (src_match && !src_hit_q) begin
                        src_hit_q <= 1'b1;
                        src_idx_q <= idx_q;
                    end
                    if (!rd_valid && !free_found_q) begin
                        free_found_q <= 1'b1;
                        free_idx_q   <= idx_q;
                    end
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == LAST) state_q <= ST_LEARN;
                end
                ST_LEARN: begin
                    mask_q  <= mask_d;
                    hit_q   <= hit_d;
                    valid_q <= 1'b1;
                    if (repl_adv) repl_q <= repl_q + 1'b1;
                    state_q <= ST_OUT;
                end
                ST_OUT: begin
                    // chain straight into the next pop to keep E+4 spacing
                    if (fwd_ready) begin
                        valid_q <= 1'b0;
                        if (!h_fifo_empty) begin
                            state_q <= ST_READ;
                            rden_q  <= 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign h_fifo_rden   = rden_q;
    assign fwd_valid     = valid_q;
    assign fwd_header    = hdr_q;
    assign fwd_port_mask = mask_q;
    assign fwd_hit       = hit_q;

endmodule

// File: tb/tb_mac_fwd_lookup.sv
// Randomized and directed bench for mac_fwd_lookup against
// a slot-level reference model of the forwarding table.
module tb_mac_fwd_lookup;

    localparam int TICK = 10;
    localparam int LIFE = 15 * TICK;

    logic         clk = 1'b0;
    logic         arst_n = 1'b0;
    logic [127:0] h_fifo_dout = '0;
    logic         h_fifo_empty = 1'b1;
    logic         h_fifo_rden;
    logic [3:0]   mask_port = '0;
    logic         flush = 1'b0;
    logic         fwd_valid;
    logic         fwd_ready = 1'b1;
    logic [127:0] fwd_header;
    logic [3:0]   fwd_port_mask;
    logic         fwd_hit;

    always #5 clk = ~clk;

    mac_fwd_lookup #(
        .HEADER_DWIDTH   (128),
        .TABLE_ADDR_LEN  (3),
        .AGE_TICK_CYCLES (TICK),
        .AGE_LIMIT       (15)
    ) dut (
        .clk           (clk),
        .arst_n        (arst_n),
        .h_fifo_dout   (h_fifo_dout),
        .h_fifo_empty  (h_fifo_empty),
        .h_fifo_rden   (h_fifo_rden),
        .mask_port     (mask_port),
        .flush         (flush),
        .fwd_valid     (fwd_valid),
        .fwd_ready     (fwd_ready),
        .fwd_header    (fwd_header),
        .fwd_port_mask (fwd_port_mask),
        .fwd_hit       (fwd_hit)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [127:0] hq[$];
    logic [127:0] exp_hdr[$];
    int           rden_t[$];
    int           rden_log[$];
    logic [3:0]   last_mask = '0;
    logic         last_hit = 1'b0;

    logic [47:0] m_mac [8];
    logic [3:0]  m_port[8];
    bit          m_val [8];
    int          m_t   [8];
    int          m_ptr = 0;
    bit          m_force = 0;

    localparam logic [47:0] BC = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] MS = 48'h0300_0000_0001;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] mk(input logic [47:0] d,
                                        input logic [47:0] s,
                                        input logic [3:0] ing);
        return {d, s, 16'h0800, 12'h000, ing};
    endfunction

    task automatic model_frame(input logic [127:0] h, input int now,
                               output logic [3:0] em, output logic eh);
        logic [47:0] d;
        logic [47:0] s;
        logic [3:0]  ing;
        logic [3:0]  fl;
        int dk;
        int sk;
        int fk;
        d   = h[127:80];
        s   = h[79:32];
        ing = h[3:0];
        fl  = ~ing & ~mask_port;
        for (int i = 0; i < 8; i++) begin
            if (m_val[i] && (now - m_t[i]) >= LIFE) m_val[i] = 0;
            if (m_force) m_val[i] = 0;
        end
        dk = -1; sk = -1; fk = -1;
        for (int i = 0; i < 8; i++) begin
            if (m_val[i] && m_mac[i] == d && dk < 0) dk = i;
            if (m_val[i] && m_mac[i] == s && sk < 0) sk = i;
            if (!m_val[i] && fk < 0) fk = i;
        end
        em = 4'b0000;
        eh = 1'b0;
        if ($countones(ing) != 1) begin
            em = 4'b0000;
        end else if (d[40] || dk < 0) begin
            em = fl;
        end else if (m_port[dk] == ing) begin
            eh = 1'b1;
        end else begin
            em = m_port[dk] & ~mask_port;
            eh = 1'b1;
        end
        if ($countones(ing) == 1 && !s[40] && !m_force) begin
            if (sk < 0) begin
                if (fk >= 0) begin
                    sk = fk;
                end else begin
                    sk = m_ptr;
                    m_ptr = (m_ptr + 1) % 8;
                end
            end
            m_val[sk] = 1;
            m_mac[sk] = s;
            m_port[sk] = ing;
            m_t[sk] = now;
        end
        m_force = 0;
    endtask

    initial forever begin
        @(posedge clk);
        if (arst_n) cyc++;
    end

    // header FIFO: data lands during the cycle after the pop strobe
    initial forever begin
        @(negedge clk);
        if (arst_n && h_fifo_rden) begin
            if (hq.size() == 0) begin
                chk("pop_empty", 128'(hq.size()), 128'd1);
            end else begin
                h_fifo_dout = hq.pop_front();
            end
            h_fifo_empty = (hq.size() == 0);
        end
    end

    initial begin
        bit pv;
        int last_rd;
        logic [127:0] h;
        logic [3:0] em;
        logic eh;
        int t;
        pv = 0;
        last_rd = 0;
        forever begin
            @(negedge clk);
            if (arst_n) begin
                if (h_fifo_rden) begin
                    last_rd = cyc;
                    rden_t.push_back(cyc);
                    rden_log.push_back(cyc);
                end
                if (fwd_valid && !pv) chk("latency", 128'(cyc - last_rd), 128'd11);
                if (fwd_valid && fwd_ready) begin
                    if (exp_hdr.size() == 0 || rden_t.size() == 0) begin
                        chk("spurious", 128'(fwd_valid), 128'd0);
                    end else begin
                        h = exp_hdr.pop_front();
                        t = rden_t.pop_front();
                        model_frame(h, t, em, eh);
                        chk("hdr", fwd_header, h);
                        chk("mask", 128'(fwd_port_mask), 128'(em));
                        chk("hit", 128'(fwd_hit), 128'(eh));
                        last_mask = fwd_port_mask;
                        last_hit = fwd_hit;
                    end
                end
                pv = fwd_valid;
            end
        end
    end

    task automatic push(input logic [127:0] h);
        hq.push_back(h);
        exp_hdr.push_back(h);
        h_fifo_empty = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_hdr.size() != 0 && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 3000) chk("drain_timeout", 128'(exp_hdr.size()), 128'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_flush();
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        for (int i = 0; i < 8; i++) m_val[i] = 0;
    endtask

    task automatic wait_rden(input int n0, input int cnt);
        int n;
        n = 0;
        while (rden_log.size() < n0 + cnt && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 400) chk("rden_timeout", 128'(rden_log.size()), 128'(n0 + cnt));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [47:0] pool[6];
        logic [47:0] d;
        logic [47:0] s;
        logic [3:0]  ig;
        logic [127:0] h;
        int n0;
        int n;

        for (int i = 0; i < 8; i++) begin
            m_val[i] = 0; m_mac[i] = '0; m_port[i] = '0; m_t[i] = 0;
        end
        for (int i = 0; i < 6; i++) pool[i] = 48'h0200_0000_0010 + 48'(i);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_rden", 128'(h_fifo_rden), 128'd0);
        chk("rst_valid", 128'(fwd_valid), 128'd0);
        chk("rst_hdr", fwd_header, 128'd0);
        chk("rst_mask", 128'(fwd_port_mask), 128'd0);
        chk("rst_hit", 128'(fwd_hit), 128'd0);
        arst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // learn then unicast
        push(mk(48'h0200_0000_0099, 48'h0200_0000_000A, 4'b0001));
        drain();
        chk("t1_flood", 128'(last_mask), 128'(4'b1110));
        push(mk(48'h0200_0000_000A, 48'h0200_0000_000B, 4'b0100));
        drain();
        chk("t1_uni", 128'(last_mask), 128'(4'b0001));
        chk("t1_hit", 128'(last_hit), 128'd1);

        // broadcast with a masked port
        mask_port = 4'b1000;
        push(mk(BC, 48'h0200_0000_00B0, 4'b0010));
        drain();
        chk("t2_bcast", 128'(last_mask), 128'(4'b0101));
        push(mk(48'h0200_0000_00B0, MS, 4'b0001));
        drain();
        chk("t2_learned", 128'(last_mask), 128'(4'b0010));
        mask_port = 4'b0000;

        // hairpin and invalid ingress
        do_flush();
        push(mk(BC, 48'h0200_0000_00C0, 4'b0100));
        push(mk(48'h0200_0000_00C0, MS, 4'b0100));
        drain();
        chk("t3_hairpin", 128'(last_mask), 128'd0);
        chk("t3_hair_hit", 128'(last_hit), 128'd1);
        push(mk(BC, 48'h0200_0000_00F0, 4'b0011));
        drain();
        chk("t3_bad_ing", 128'(last_mask), 128'd0);
        push(mk(48'h0200_0000_00F0, MS, 4'b0001));
        drain();
        chk("t3_not_learned", 128'(last_mask), 128'(4'b1110));

        // table full and replacement pointer
        do_flush();
        for (int k = 0; k < 9; k++) push(mk(BC, 48'h0200_0000_0100 + 48'(k), 4'b0001));
        push(mk(48'h0200_0000_0100, MS, 4'b0010));
        push(mk(BC, 48'h0200_0000_0109, 4'b0001));
        push(mk(48'h0200_0000_0101, MS, 4'b0010));
        push(mk(48'h0200_0000_0102, MS, 4'b0010));
        drain();
        chk("t4_kept", 128'(last_mask), 128'(4'b0001));
        chk("t4_ptr", 128'(m_ptr), 128'd2);

        // aging
        do_flush();
        push(mk(BC, 48'h0200_0000_0200, 4'b0001));
        drain();
        repeat (200) @(posedge clk);
        #1;
        push(mk(48'h0200_0000_0200, MS, 4'b0100));
        drain();
        chk("t5_aged", 128'(last_mask), 128'(4'b1011));
        chk("t5_aged_hit", 128'(last_hit), 128'd0);

        // flush during the scan
        do_flush();
        push(mk(BC, 48'h0200_0000_0300, 4'b0010));
        drain();
        n0 = rden_log.size();
        push(mk(48'h0200_0000_0300, 48'h0200_0000_0301, 4'b0001));
        wait_rden(n0, 1);
        repeat (3) @(posedge clk);
        #1;
        flush = 1'b1;
        m_force = 1;
        @(posedge clk); #1;
        flush = 1'b0;
        drain();
        chk("t5_force", 128'(last_mask), 128'(4'b1110));
        chk("t5_force_hit", 128'(last_hit), 128'd0);
        push(mk(48'h0200_0000_0301, MS, 4'b0100));
        drain();
        chk("t5_nolearn", 128'(last_mask), 128'(4'b1011));

        // backpressure
        do_flush();
        fwd_ready = 1'b0;
        h = mk(BC, 48'h0200_0000_0400, 4'b0001);
        push(h);
        n = 0;
        while (!fwd_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("t6_valid", 128'(fwd_valid), 128'd1);
        push(mk(48'h0200_0000_0400, MS, 4'b0010));
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("bp_hdr", fwd_header, h);
            chk("bp_mask", 128'(fwd_port_mask), 128'(4'b1110));
            chk("bp_rden", 128'(h_fifo_rden), 128'd0);
        end
        @(posedge clk); #1;
        fwd_ready = 1'b1;
        drain();
        chk("t6_after", 128'(last_mask), 128'(4'b0001));

        // rate with three queued headers
        n0 = rden_log.size();
        for (int k = 0; k < 3; k++) push(mk(BC, 48'h0200_0000_0500 + 48'(k), 4'b0010));
        wait_rden(n0, 3);
        if (rden_log.size() >= n0 + 3) begin
            chk("rate01", 128'(rden_log[n0+1] - rden_log[n0]), 128'd12);
            chk("rate12", 128'(rden_log[n0+2] - rden_log[n0+1]), 128'd12);
        end
        drain();

        // randomized batches, each short enough that nothing ages out
        for (int b = 0; b < 12; b++) begin
            do_flush();
            mask_port = 4'($urandom_range(0, 15));
            for (int k = 0; k < 6; k++) begin
                n = $urandom_range(0, 9);
                if (n < 6) d = pool[n];
                else if (n < 8) d = BC;
                else if (n == 8) d = {16'h0600, 32'($urandom)};
                else d = 48'h0100_5E00_0001;
                n = $urandom_range(0, 7);
                s = (n < 6) ? pool[n] : ((n == 6) ? pool[0] : MS);
                if ($urandom_range(0, 4) == 0) ig = 4'($urandom_range(0, 15));
                else ig = 4'(1 << $urandom_range(0, 3));
                push(mk(d, s, ig));
            end
            n = 0;
            while (exp_hdr.size() != 0 && n < 2000) begin
                fwd_ready = ($urandom_range(0, 3) != 0);
                @(posedge clk); #1;
                n++;
            end
            fwd_ready = 1'b1;
            drain();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
